branch_npc_unit: RTL and testbench
==================================

// Module: branch_npc_unit
// PURPOSE
//  Next-PC stage downstream of the selective comparer: consumes the 1-bit compare result
//  (S[0]) for the branch in ID, computes branch/jump targets and owns the fetch PC register.
//  Implements one architectural delay slot and a fetch handshake toward instruction memory;
//  a redirect that cannot be taken while fetch is blocked is latched and applied later.
// PARAMETERS
//  RESET_PC     32'h0000_3000  fetch PC after reset
//  PC_STEP      4              byte increment per sequential fetch
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   synchronous, active-high
//  stall         in   1   hazard stall from ID: hold PC and ignore ID control this cycle
//  id_valid      in   1   ID holds a real instruction (0 = bubble)
//  id_branch     in   1   ID instruction is a conditional branch
//  id_jump_imm   in   1   j/jal (26-bit index)
//  id_jump_reg   in   1   jr/jalr
//  cmp_taken     in   1   comparer output bit 0 for the ID branch
//  id_pc         in   32  PC of the ID instruction
//  id_imm16      in   16  branch offset (words, signed)
//  id_index26    in   26  jump index
//  id_rs_value   in   32  forwarded register target for jr/jalr
//  fetch_ready   in   1   imem accepts fetch_pc this cycle
//  fetch_pc      out  32  address presented to imem
//  fetch_valid   out  1   fetch_pc is a real request
//  link_addr     out  32  id_pc + 8 (jal/jalr/bgezal write-back)
//  redirect      out  1   a control transfer was resolved this cycle
//  pending       out  1   a resolved target is latched awaiting fetch_ready
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, fetch_valid=0 on the reset cycle then 1, pending=0, redirect=0.
//  - Target arithmetic (all 32-bit, wrap modulo 2^32):
//      branch: id_pc + 4 + ({{14{imm[15]}},imm,2'b00});  j: {id_pc[31:28],index,2'b00};
//      jr: id_rs_value (no alignment check here).  link_addr = id_pc + 8 combinational.
//  - Resolve (comb): take = id_valid & ~stall & (id_jump_imm | id_jump_reg | id_branch&cmp_taken).
//    redirect = take. Not-taken branch is not a redirect. Priority jump_reg > jump_imm > branch
//    if more than one is set (decoder error, must not X).
//  - Delay slot: instruction at id_pc+4 is already fetched/being fetched; it is never squashed.
//    Target is applied as the fetch address AFTER the delay slot has been accepted by imem.
//  - FSM states (2-bit): SEQ, SLOT, PEND.
//      SEQ : fetch_ready & ~stall -> fetch_pc += PC_STEP. take -> latch target, go SLOT.
//      SLOT: delay slot fetch outstanding; on fetch_ready&~stall -> fetch_pc=target, go SEQ;
//            if not accepted go PEND (pending=1). 
//      PEND: hold target; on fetch_ready&~stall -> fetch_pc=target, go SEQ.
//    In SLOT/PEND a new take is ignored (a branch in a delay slot is UNPREDICTABLE: keep first).
//  - stall=1: fetch_pc, state, latched target all hold; cmp_taken is don't-care.
//  - fetch_ready=0: fetch_pc holds; state advances only SLOT->PEND.
//  - take and fetch_ready in the same SEQ cycle: PC advances to delay slot AND target latches.
//  - Reset asserted mid-PEND: discard target, return to SEQ with RESET_PC next cycle.
//  - Latency: redirect visible combinationally; new fetch_pc one edge after slot accepted.
// STRUCTURE
//  - Shared package (cpu_defs): RESET_PC, PC_STEP, npc state encoding, instr field widths.
//  - One sub-module natural: npc_target_calc (pure comb target mux + link adder);
//    FSM and PC register stay in this module.
// TESTING
//  1 reset held 2 cycles, fetch_ready=1 -> fetch_pc 3000, then 3004, 3008 each cycle.
//  2 beq at id_pc=3004, imm=0x0003, cmp_taken=1 -> redirect=1; fetch 3008 (slot) then 3014.
//  3 same branch cmp_taken=0 -> redirect=0; fetch sequence 3008, 300C unchanged.
//  4 jr id_rs_value=0000_3100 with fetch_ready=0 for 3 cycles after slot -> pending=1, fetch_pc
//    holds 3008; on fetch_ready=1 -> 3100 next edge, pending=0.
//  5 stall=1 for 2 cycles with j index=0x0000C40 in ID -> no redirect, PC frozen; after release
//    -> redirect, slot fetched, then fetch_pc=0000_3100.
//  6 reset pulsed while PEND with target 3100 -> fetch_pc=3000, pending=0, no jump to 3100.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch reset vector, PC step,
// next-PC FSM state encoding and instruction field widths.
package cpu_defs_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  localparam int IMM_W = 16;
  localparam int IDX_W = 26;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_SLOT = 2'd1,
    NPC_PEND = 2'd2
  } npc_state_e;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational control-transfer target mux and link adder.
// In: id_pc, imm16, index26, rs_value, jump flags. Out: target, link_addr.
module npc_target_calc
  import cpu_defs_pkg::*;
(
  input  logic [31:0]      id_pc,
  input  logic [IMM_W-1:0] id_imm16,
  input  logic [IDX_W-1:0] id_index26,
  input  logic [31:0]      id_rs_value,
  input  logic             id_jump_imm,
  input  logic             id_jump_reg,
  output logic [31:0]      target,
  output logic [31:0]      link_addr
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign br_tgt = id_pc + 32'd4
                + {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign j_tgt  = {id_pc[31:28], id_index26, 2'b00};

  assign link_addr = id_pc + 32'd8;

  // Several flags at once is a decoder fault; resolve
  // deterministically: jump_reg, then jump_imm, then branch.
  always_comb begin
    target = br_tgt;
    if (id_jump_reg)
      target = id_rs_value;
    else if (id_jump_imm)
      target = j_tgt;
  end

endmodule

// File: rtl/branch_npc_unit.sv
// Next-PC stage: resolves branches/jumps from ID, owns fetch PC,
// honours one delay slot and latches targets while imem is not ready.
module branch_npc_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        id_branch,
  input  logic        id_jump_imm,
  input  logic        id_jump_reg,
  input  logic        cmp_taken,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_value,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic [31:0] link_addr,
  output logic        redirect,
  output logic        pending
);

  npc_state_e  state;
  logic [31:0] tgt_q;
  logic [31:0] target;
  logic        take;
  logic        accept;

  npc_target_calc u_calc (
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .id_index26  (id_index26),
    .id_rs_value (id_rs_value),
    .id_jump_imm (id_jump_imm),
    .id_jump_reg (id_jump_reg),
    .target      (target),
    .link_addr   (link_addr)
  );

  assign take = id_valid & ~stall
              & (id_jump_imm | id_jump_reg
                 | (id_branch & cmp_taken));

  assign redirect = take;
  assign accept   = fetch_valid & fetch_ready & ~stall;
  assign pending  = (state == NPC_PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      state       <= NPC_SEQ;
      tgt_q       <= '0;
    end else begin
      fetch_valid <= 1'b1;
      unique case (state)
        NPC_SEQ: begin
          if (accept)
            fetch_pc <= fetch_pc + PC_STEP;
          if (take) begin
            tgt_q <= target;
            state <= NPC_SLOT;
          end
        end
        NPC_SLOT: begin
          if (accept) begin
            fetch_pc <= tgt_q;
            state    <= NPC_SEQ;
          end else if (!stall) begin
            state <= NPC_PEND;
          end
        end
        NPC_PEND: begin
          if (accept) begin
            fetch_pc <= tgt_q;
            state    <= NPC_SEQ;
          end
        end
        default: state <= NPC_SEQ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_npc_unit.sv
// Testbench for branch_npc_unit: expected fetch addresses are queued
// as stimulus is driven and compared on each accepted fetch.
module tb_branch_npc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        id_valid;
  logic        id_branch;
  logic        id_jump_imm;
  logic        id_jump_reg;
  logic        cmp_taken;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] id_rs_value;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] link_addr;
  logic        redirect;
  logic        pending;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sbq[$];

  branch_npc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .id_valid    (id_valid),
    .id_branch   (id_branch),
    .id_jump_imm (id_jump_imm),
    .id_jump_reg (id_jump_reg),
    .cmp_taken   (cmp_taken),
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .id_index26  (id_index26),
    .id_rs_value (id_rs_value),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .link_addr   (link_addr),
    .redirect    (redirect),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every fetch imem accepts must match the next queued address.
  always @(negedge clk) begin
    if (!reset && fetch_valid && fetch_ready && !stall) begin
      if (sbq.size() == 0)
        check("sb_empty", 32'(sbq.size()), 32'd1);
      else
        check("fetch_pc", fetch_pc, sbq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid    = 1'b0;
    id_branch   = 1'b0;
    id_jump_imm = 1'b0;
    id_jump_reg = 1'b0;
    cmp_taken   = 1'b0;
    id_pc       = '0;
    id_imm16    = '0;
    id_index26  = '0;
    id_rs_value = '0;
  endtask

  // Leaves the bench in the first valid fetch cycle (pc=3000).
  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    fetch_ready = 1'b1;
    clear_id();
    tick();
    tick();
    wait_neg();
    check("rst_pc", fetch_pc, 32'h0000_3000);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_rd", 32'(redirect), 32'd0);
    reset = 1'b0;
    tick();
    check("fv_up", 32'(fetch_valid), 32'd1);
  endtask

  task automatic run_ctl(string tag, logic v, logic br,
                         logic ji, logic jr, logic cmp,
                         logic [15:0] imm, logic [25:0] idx,
                         logic [31:0] rs, logic exp_rd,
                         logic [31:0] exp_tgt);
    do_reset();
    sbq.push_back(32'h3000);
    sbq.push_back(32'h3004);
    sbq.push_back(32'h3008);
    sbq.push_back(exp_rd ? exp_tgt : 32'h300C);
    tick();
    id_valid    = v;
    id_branch   = br;
    id_jump_imm = ji;
    id_jump_reg = jr;
    cmp_taken   = cmp;
    id_imm16    = imm;
    id_index26  = idx;
    id_rs_value = rs;
    id_pc       = 32'h3004;
    wait_neg();
    check({tag, "_rd"}, 32'(redirect), 32'(exp_rd));
    check({tag, "_link"}, link_addr, 32'h300C);
    tick();
    clear_id();
    wait_neg();
    check({tag, "_pend"}, 32'(pending), 32'd0);
    tick();
    wait_neg();
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    fetch_ready = 1'b1;
    clear_id();

    run_ctl("beq_t", 1, 1, 0, 0, 1, 16'h0003, '0, '0,
            1, 32'h3014);
    run_ctl("beq_nt", 1, 1, 0, 0, 0, 16'h0003, '0, '0,
            0, 32'h0);
    run_ctl("beq_neg", 1, 1, 0, 0, 1, 16'hFFFE, '0, '0,
            1, 32'h3000);
    run_ctl("j", 1, 0, 1, 0, 0, '0, 26'hC40, '0,
            1, 32'h3100);
    run_ctl("prio_jr", 1, 1, 1, 1, 1, 16'h0003, 26'hC40,
            32'h5000, 1, 32'h5000);
    run_ctl("prio_j", 1, 1, 1, 0, 1, 16'h0003, 26'hC40,
            '0, 1, 32'h3100);
    run_ctl("bubble", 0, 0, 1, 0, 0, '0, 26'hC40, '0,
            0, 32'h0);

    // jr target latched while imem stalls the delay slot
    do_reset();
    sbq.push_back(32'h3000);
    sbq.push_back(32'h3004);
    sbq.push_back(32'h3008);
    sbq.push_back(32'h3100);
    tick();
    id_valid = 1'b1;
    id_jump_reg = 1'b1;
    id_rs_value = 32'h3100;
    id_pc = 32'h3004;
    wait_neg();
    check("jr_rd", 32'(redirect), 32'd1);
    tick();
    clear_id();
    fetch_ready = 1'b0;
    wait_neg();
    check("jr_slot_pend", 32'(pending), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      wait_neg();
      check("jr_hold_pc", fetch_pc, 32'h3008);
      check("jr_hold_pend", 32'(pending), 32'd1);
    end
    tick();
    fetch_ready = 1'b1;
    wait_neg();
    check("jr_rel_pend", 32'(pending), 32'd1);
    tick();
    wait_neg();
    check("jr_tgt_pc", fetch_pc, 32'h3100);
    check("jr_done_pend", 32'(pending), 32'd0);

    // j held in ID by a hazard stall
    do_reset();
    sbq.push_back(32'h3000);
    sbq.push_back(32'h3004);
    sbq.push_back(32'h3008);
    sbq.push_back(32'h3100);
    tick();
    stall = 1'b1;
    id_valid = 1'b1;
    id_jump_imm = 1'b1;
    id_index26 = 26'hC40;
    id_pc = 32'h3004;
    for (int i = 0; i < 2; i++) begin
      wait_neg();
      check("stl_rd", 32'(redirect), 32'd0);
      check("stl_pc", fetch_pc, 32'h3004);
      tick();
    end
    stall = 1'b0;
    wait_neg();
    check("stl_rel_rd", 32'(redirect), 32'd1);
    tick();
    clear_id();
    wait_neg();
    check("stl_slot_pc", fetch_pc, 32'h3008);
    tick();
    wait_neg();
    check("stl_tgt_pc", fetch_pc, 32'h3100);

    // reset while a target is pending must discard it
    do_reset();
    sbq.push_back(32'h3000);
    sbq.push_back(32'h3004);
    tick();
    id_valid = 1'b1;
    id_jump_reg = 1'b1;
    id_rs_value = 32'h3100;
    id_pc = 32'h3004;
    tick();
    clear_id();
    fetch_ready = 1'b0;
    tick();
    wait_neg();
    check("rp_pend", 32'(pending), 32'd1);
    tick();
    reset = 1'b1;
    fetch_ready = 1'b1;
    tick();
    reset = 1'b0;
    wait_neg();
    check("rp_pc", fetch_pc, 32'h3000);
    check("rp_pend0", 32'(pending), 32'd0);
    check("rp_fv", 32'(fetch_valid), 32'd0);
    sbq.push_back(32'h3000);
    sbq.push_back(32'h3004);
    sbq.push_back(32'h3008);
    for (int i = 0; i < 3; i++) begin
      tick();
      wait_neg();
    end

    reset = 1'b1;
    tick();
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
